// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds FSM encodings, digit-adjust constants and the range helper.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] DIG_ADJ_MIN = 4'd5;
    localparam logic [3:0] DIG_ADJ_ADD = 4'd3;

    // Largest magnitude that fits in ndig decimal digits: 10^ndig - 1.
    function automatic logic [63:0] bcd_max(input int ndig);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < ndig; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3_digit.sv
// Single-digit double-dabble correction.
// Digits of 5 or more get +3 so the following shift carries correctly.
module bcd_add3_digit
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    assign d_out = (d_in >= DIG_ADJ_MIN) ? (d_in + DIG_ADJ_ADD) : d_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential signed binary to BCD converter (shift-and-add-3).
// Results are committed in one cycle and held between conversions.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NDIG  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  val,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic              neg,
    output logic [4*NDIG-1:0] bcd,
    output logic              overflow
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [63:0]   BCD_MAX  = bcd_max(NDIG);

    state_t state;
    state_t state_nx;

    logic load;
    logic shift;
    logic commit;

    logic             neg_r;
    logic             ovf_r;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] mag_in;
    logic [BW-1:0]    acc;
    logic [BW-1:0]    acc_adj;
    logic [CW-1:0]    cnt;

    logic          done_q;
    logic          valid_q;
    logic          neg_q;
    logic          ovf_q;
    logic [BW-1:0] bcd_q;

    assign mag_in = val[WIDTH-1] ? (~val + WIDTH'(1)) : val;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_add3_digit u_add3 (
            .d_in  (acc[4*g +: 4]),
            .d_out (acc_adj[4*g +: 4])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CONV;
            CONV:    if (cnt == CNT_LAST) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control strobes and busy flag decoded from the current state.
    always_comb begin
        busy   = (state != IDLE);
        load   = (state == IDLE) && start;
        shift  = (state == CONV);
        commit = (state == COMMIT);
    end

    // Conversion engine: load operand, iterate, then commit results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_r   <= 1'b0;
            ovf_r   <= 1'b0;
            mag     <= '0;
            acc     <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            done_q <= commit;
            if (load) begin
                neg_r <= val[WIDTH-1];
                mag   <= mag_in;
                ovf_r <= (64'(mag_in) > BCD_MAX);
                acc   <= '0;
                cnt   <= '0;
            end
            if (shift) begin
                acc <= {acc_adj[BW-2:0], mag[WIDTH-1]};
                mag <= {mag[WIDTH-2:0], 1'b0};
                cnt <= cnt + CW'(1);
            end
            if (commit) begin
                bcd_q   <= acc;
                neg_q   <= neg_r;
                ovf_q   <= ovf_r;
                valid_q <= 1'b1;
            end
        end
    end

    assign done     = done_q;
    assign valid    = valid_q;
    assign neg      = neg_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: directed and random conversions
// checked against an arithmetic decimal reference model.
module tb_bin_to_bcd_seq;

    localparam int W = 32;
    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] val;
    logic         busy;
    logic         done;
    logic         valid;
    logic         neg;
    logic [4*N-1:0] bcd;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.WIDTH(W), .NDIG(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .val      (val),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .neg      (neg),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned m_mag(input logic [W-1:0] v);
        if (v[W-1]) return 64'h1_0000_0000 - 64'(v);
        return 64'(v);
    endfunction

    function automatic logic [4*N-1:0] m_bcd(input logic [W-1:0] v);
        longint unsigned r;
        logic [4*N-1:0] b;
        r = m_mag(v) % 64'd100000;
        b = '0;
        for (int i = 0; i < N; i++) begin
            b[4*i +: 4] = 4'(r % 64'd10);
            r = r / 64'd10;
        end
        return b;
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] v);
        return m_mag(v) > 64'd99999;
    endfunction

    task automatic chk_result(input string tag, input logic [W-1:0] v);
        chk({tag, ".bcd"}, 64'(bcd), 64'(m_bcd(v)));
        chk({tag, ".neg"}, 64'(neg), 64'(v[W-1]));
        chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf(v)));
        chk({tag, ".valid"}, 64'(valid), 64'(1));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
    endtask

    // Runs one conversion; optionally re-pulses start at cycle rep_at.
    task automatic convert(input string tag, input logic [W-1:0] v,
                           input int rep_at, input logic [W-1:0] rep_v);
        int n;
        logic [4*N-1:0] prev_bcd;
        logic prev_neg;
        logic prev_ovf;
        prev_bcd = bcd;
        prev_neg = neg;
        prev_ovf = overflow;
        @(negedge clk);
        start = 1'b1;
        val   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        val   = $urandom;
        chk({tag, ".busy_on"}, 64'(busy), 64'(1));
        n = 0;
        while (!done && n < 100) begin
            if (n == rep_at) begin
                start = 1'b1;
                val   = rep_v;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (n == 16) begin
                chk({tag, ".hold_bcd"}, 64'(bcd), 64'(prev_bcd));
                chk({tag, ".hold_neg"}, 64'(neg), 64'(prev_neg));
                chk({tag, ".hold_ovf"}, 64'(overflow), 64'(prev_ovf));
            end
        end
        chk({tag, ".latency"}, 64'(n), 64'(33));
        chk_result(tag, v);
    endtask

    // Starts a conversion and asserts reset after 'at' cycles.
    task automatic abort_at(input string tag, input logic [W-1:0] v,
                            input int at);
        int pulses;
        @(negedge clk);
        start = 1'b1;
        val   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (at) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk({tag, ".done"}, 64'(done), 64'(0));
        chk({tag, ".valid"}, 64'(valid), 64'(0));
        chk({tag, ".bcd"}, 64'(bcd), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk({tag, ".quiet"}, 64'(pulses), 64'(0));
        chk({tag, ".valid_after"}, 64'(valid), 64'(0));
    endtask

    initial begin
        logic [W-1:0] rv;
        rst   = 1'b1;
        start = 1'b0;
        val   = '0;
        #2;
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.valid", 64'(valid), 64'(0));
        chk("rst.neg", 64'(neg), 64'(0));
        chk("rst.bcd", 64'(bcd), 64'(0));
        chk("rst.ovf", 64'(overflow), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        abort_at("abort10", 32'd555, 10);

        convert("v12345", 32'd12345, -1, '0);
        chk("v12345.raw", 64'(bcd), 64'h12345);
        @(posedge clk);
        #1;
        chk("v12345.done_once", 64'(done), 64'(0));

        convert("m42", 32'hFFFF_FFD6, -1, '0);
        chk("m42.raw", 64'(bcd), 64'h00042);
        convert("v100000", 32'd100000, -1, '0);
        convert("min", 32'h8000_0000, -1, '0);
        chk("min.raw", 64'(bcd), 64'h83648);
        convert("zero", 32'd0, -1, '0);

        convert("rep7", 32'd7, 10, 32'd9);
        convert("b2b", 32'd99999, -1, '0);
        chk("b2b.raw", 64'(bcd), 64'h99999);
        @(posedge clk);
        #1;
        chk("b2b.done_once", 64'(done), 64'(0));

        abort_at("abort15", 32'd424242, 15);

        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) rv = $urandom;
            else if (i % 3 == 1) rv = 32'($urandom_range(0, 200000));
            else rv = -32'($urandom_range(0, 200000));
            convert($sformatf("rnd%0d", i), rv, -1, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
